// File: rtl/nfc_pkg.sv
// Constants and types shared by the NAND command executors on the common ACG port.
package nfc_pkg;

  localparam int unsigned AcgCaLatchBit = 6;
  localparam int unsigned AcgDataOutBit = 5;
  localparam int unsigned AcgDataInBit  = 4;

  localparam logic [7:0] NandGetFeatures = 8'hEE;
  localparam logic [7:0] NandSetFeatures = 8'hEF;

  localparam int unsigned FeatureParamBytes = 4;

  typedef enum logic [3:0] {
    StReset,
    StReady,
    StCmdLatch,
    StCmdIssue,
    StAddrIssue,
    StWaitRbLow,
    StWaitRbHigh,
    StDataRead,
    StResultOut
  } get_feature_state_e;

endpackage

// File: rtl/nfc_command_get_feature_if.sv
// Command bus plus ACG port of a command executor; slave is the executor's view.
interface nfc_command_get_feature_if #(
  parameter int unsigned NumberOfWays = 4
);
  logic [5:0]              iOpcode;
  logic [7:0]              iAddress;
  logic                    iCMDValid;
  logic                    oCMDReady;
  logic [NumberOfWays-1:0] iWaySelect;
  logic                    oStart;
  logic                    oLastStep;
  logic [31:0]             oReadData;
  logic                    oReadLast;
  logic                    oReadValid;
  logic                    iReadReady;
  logic [7:0]              oACG_Command;
  logic [2:0]              oACG_CommandOption;
  logic [7:0]              iACG_Ready;
  logic [7:0]              iACG_LastStep;
  logic [NumberOfWays-1:0] oACG_TargetWay;
  logic [15:0]             oACG_NumOfData;
  logic                    oACG_CASelect;
  logic [39:0]             oACG_CAData;
  logic [15:0]             iACG_ReadData;
  logic                    iACG_ReadLast;
  logic                    iACG_ReadValid;
  logic                    oACG_ReadReady;
  logic [NumberOfWays-1:0] iACG_ReadyBusy;

  modport slave (
    input  iOpcode, iAddress, iCMDValid, iWaySelect, iReadReady, iACG_Ready, iACG_LastStep,
           iACG_ReadData, iACG_ReadLast, iACG_ReadValid, iACG_ReadyBusy,
    output oCMDReady, oStart, oLastStep, oReadData, oReadLast, oReadValid, oACG_Command,
           oACG_CommandOption, oACG_TargetWay, oACG_NumOfData, oACG_CASelect, oACG_CAData,
           oACG_ReadReady
  );

  modport master (
    output iOpcode, iAddress, iCMDValid, iWaySelect, iReadReady, iACG_Ready, iACG_LastStep,
           iACG_ReadData, iACG_ReadLast, iACG_ReadValid, iACG_ReadyBusy,
    input  oCMDReady, oStart, oLastStep, oReadData, oReadLast, oReadValid, oACG_Command,
           oACG_CommandOption, oACG_TargetWay, oACG_NumOfData, oACG_CASelect, oACG_CAData,
           oACG_ReadReady
  );
endinterface

// File: rtl/nfc_rb_sync.sv
// Two-stage ready/busy synchroniser: masks R/B# by the target ways, then ORs them (1 = ready).
module nfc_rb_sync #(
  parameter int unsigned NumberOfWays = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NumberOfWays-1:0] target_way,
  input  logic [NumberOfWays-1:0] ready_busy,
  output logic                    way_rb
);

  logic [NumberOfWays-1:0] busy_q;
  logic                    way_rb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      way_rb_q <= 1'b0;
    end else begin
      busy_q   <= target_way & ready_busy;
      way_rb_q <= |busy_q;
    end
  end

  assign way_rb = way_rb_q;

endmodule

// File: rtl/nfc_command_get_feature.sv
// GET FEATURES executor: issues EEh + address, waits out R/B#, reads P1..P4 as one 32-bit word.
module nfc_command_get_feature
  import nfc_pkg::*;
#(
  parameter int unsigned NumberOfWays = 4,
  parameter logic [5:0]  CommandID    = 6'b000011,
  parameter logic [4:0]  TargetID     = 5'b00101
) (
  input logic                      iSystemClock,
  input logic                      iReset_n,
  nfc_command_get_feature_if.slave bus
);

  get_feature_state_e state_q, state_d;

  logic                    start;
  logic                    way_rb;
  logic                    data_hs;
  logic [NumberOfWays-1:0] target_way_q;
  logic [7:0]              feature_addr_q;
  logic [31:0]             read_data_q;
  logic [1:0]              word_cnt_q;
  logic [7:0]              acg_cmd_d, acg_cmd_q;
  logic [15:0]             num_data_d, num_data_q;
  logic                    ca_sel_d, ca_sel_q;
  logic [39:0]             ca_data_d, ca_data_q;
  logic                    acg_rd_ready_q;
  logic                    cmd_ready_q;
  logic                    last_step_q;
  logic                    read_valid_q;
  logic                    unused_inputs;

  assign start   = (bus.iOpcode == CommandID) & bus.iCMDValid;
  assign data_hs = bus.iACG_ReadValid & acg_rd_ready_q;

  // Target id is reserved; ACG ready flags and data-in last are not needed by this sequence.
  assign unused_inputs = ^{TargetID, bus.iACG_Ready, bus.iACG_ReadLast, bus.iACG_LastStep};

  nfc_rb_sync #(
    .NumberOfWays(NumberOfWays)
  ) u_rb_sync (
    .clk       (iSystemClock),
    .rst_n     (iReset_n),
    .target_way(target_way_q),
    .ready_busy(bus.iACG_ReadyBusy),
    .way_rb    (way_rb)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:      state_d = StReady;
      StReady:      if (start) state_d = StCmdLatch;
      StCmdLatch:   state_d = StCmdIssue;
      StCmdIssue:   if (bus.iACG_LastStep[AcgCaLatchBit]) state_d = StAddrIssue;
      StAddrIssue:  if (bus.iACG_LastStep[AcgCaLatchBit]) state_d = StWaitRbLow;
      StWaitRbLow:  if (!way_rb) state_d = StWaitRbHigh;
      StWaitRbHigh: if (way_rb) state_d = StDataRead;
      StDataRead:   if (bus.iACG_LastStep[AcgDataInBit]) state_d = StResultOut;
      StResultOut:  if (bus.iReadReady) state_d = StReady;
      default:      state_d = StReset;
    endcase
  end

  // ACG request decoded from the next state so it is registered alongside the transition.
  always_comb begin
    acg_cmd_d  = '0;
    num_data_d = '0;
    ca_sel_d   = 1'b1;
    ca_data_d  = '0;
    unique case (state_d)
      StCmdIssue: begin
        acg_cmd_d[AcgCaLatchBit] = 1'b1;
        num_data_d               = 16'd1;
        ca_data_d                = {NandGetFeatures, 32'h0};
      end
      StAddrIssue: begin
        acg_cmd_d[AcgCaLatchBit] = 1'b1;
        num_data_d               = 16'd1;
        ca_sel_d                 = 1'b0;
        ca_data_d                = {feature_addr_q, 32'h0};
      end
      StDataRead: begin
        acg_cmd_d[AcgDataInBit] = 1'b1;
        num_data_d              = 16'(FeatureParamBytes);
      end
      default: ;
    endcase
  end

  always_ff @(posedge iSystemClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q        <= StReset;
      target_way_q   <= '0;
      feature_addr_q <= '0;
      read_data_q    <= '0;
      word_cnt_q     <= '0;
      acg_cmd_q      <= '0;
      num_data_q     <= '0;
      ca_sel_q       <= 1'b1;
      ca_data_q      <= '0;
      acg_rd_ready_q <= 1'b0;
      cmd_ready_q    <= 1'b1;
      last_step_q    <= 1'b0;
      read_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      acg_cmd_q      <= acg_cmd_d;
      num_data_q     <= num_data_d;
      ca_sel_q       <= ca_sel_d;
      ca_data_q      <= ca_data_d;
      acg_rd_ready_q <= (state_d == StDataRead);
      cmd_ready_q    <= (state_d == StReady);
      read_valid_q   <= (state_d == StResultOut);
      last_step_q    <= (state_q == StResultOut) && bus.iReadReady;
      if ((state_q == StReady) && start) begin
        target_way_q   <= bus.iWaySelect;
        feature_addr_q <= bus.iAddress;
      end
      if (state_q == StCmdLatch) begin
        read_data_q <= '0;
        word_cnt_q  <= '0;
      end else if ((state_q == StDataRead) && data_hs && (word_cnt_q != 2'd2)) begin
        // P1,P2 land in the upper half, P3,P4 in the lower; later words are dropped.
        if (word_cnt_q == 2'd0) read_data_q[31:16] <= bus.iACG_ReadData;
        else                    read_data_q[15:0]  <= bus.iACG_ReadData;
        word_cnt_q <= word_cnt_q + 2'd1;
      end
    end
  end

  assign bus.oStart             = start;
  assign bus.oCMDReady          = cmd_ready_q;
  assign bus.oLastStep          = last_step_q;
  assign bus.oReadData          = read_data_q;
  assign bus.oReadLast          = read_valid_q;
  assign bus.oReadValid         = read_valid_q;
  assign bus.oACG_Command       = acg_cmd_q;
  assign bus.oACG_CommandOption = 3'b000;
  assign bus.oACG_TargetWay     = target_way_q;
  assign bus.oACG_NumOfData     = num_data_q;
  assign bus.oACG_CASelect      = ca_sel_q;
  assign bus.oACG_CAData        = ca_data_q;
  assign bus.oACG_ReadReady     = acg_rd_ready_q;

endmodule

// File: tb/tb_nfc_command_get_feature.sv
// Bench for the GET FEATURES executor: ACG/NAND model driven per transaction, results scoreboarded.
module tb_nfc_command_get_feature;

  localparam logic [5:0]   CmdId    = 6'b000011;
  localparam logic [108:0] ResetVec = {1'b1, 3'b000, 32'h0, 8'h0, 3'h0, 4'h0, 16'h0, 1'b1,
                                       40'h0, 1'b0};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  nfc_command_get_feature_if #(.NumberOfWays(4)) bus ();

  nfc_command_get_feature #(
    .NumberOfWays(4),
    .CommandID   (CmdId),
    .TargetID    (5'b00101)
  ) dut (
    .iSystemClock(clk),
    .iReset_n    (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic logic [108:0] out_vec();
    return {bus.oCMDReady, bus.oLastStep, bus.oReadValid, bus.oReadLast, bus.oReadData,
            bus.oACG_Command, bus.oACG_CommandOption, bus.oACG_TargetWay, bus.oACG_NumOfData,
            bus.oACG_CASelect, bus.oACG_CAData, bus.oACG_ReadReady};
  endfunction

  task automatic idle_inputs();
    bus.iOpcode        = '0;
    bus.iAddress       = '0;
    bus.iCMDValid      = 1'b0;
    bus.iWaySelect     = '0;
    bus.iReadReady     = 1'b0;
    bus.iACG_Ready     = 8'hFF;
    bus.iACG_LastStep  = '0;
    bus.iACG_ReadData  = '0;
    bus.iACG_ReadLast  = 1'b0;
    bus.iACG_ReadValid = 1'b0;
    bus.iACG_ReadyBusy = '1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (out_vec() !== ResetVec) $display("FAIL reset_outputs: got %h want %h", out_vec(), ResetVec);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.oCMDReady !== 1'b1 || bus.oACG_Command !== 8'h00)
      $display("FAIL reset_release: got rdy=%b cmd=%h want rdy=1 cmd=00", bus.oCMDReady,
               bus.oACG_Command);
    else n_pass++;
  endtask

  task automatic test_wrong_opcode();
    bit ok = 1'b1;
    bus.iOpcode    = 6'b000010;
    bus.iAddress   = 8'h55;
    bus.iWaySelect = 4'b0001;
    bus.iCMDValid  = 1'b1;
    #1;
    n_checks++;
    if (bus.oStart !== 1'b0) $display("FAIL wrong_op_start: got %b want 0", bus.oStart);
    else n_pass++;
    repeat (5) begin
      @(negedge clk);
      if (bus.oStart !== 1'b0 || bus.oCMDReady !== 1'b1 || bus.oACG_Command !== 8'h00) ok = 1'b0;
    end
    n_checks++;
    if (!ok) $display("FAIL wrong_op_idle: got start/ready/cmd disturbed want idle READY");
    else n_pass++;
    idle_inputs();
    @(negedge clk);
  endtask

  // One full transaction; abort asserts reset partway through the data-in phase.
  task automatic run_op(input string name, input logic [7:0] addr, input logic [3:0] way,
                        input int nwords, input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input int rb_low, input int rdy_delay,
                        input bit abort);
    logic [15:0] words[3];
    logic [31:0] got, exp;
    int t;
    bit ok;
    words[0] = w0;
    words[1] = w1;
    words[2] = w2;
    exp = {(nwords > 0) ? w0 : 16'h0, (nwords > 1) ? w1 : 16'h0};
    if (!abort) exp_q.push_back(exp);

    bus.iOpcode    = CmdId;
    bus.iAddress   = addr;
    bus.iWaySelect = way;
    bus.iCMDValid  = 1'b1;
    #1;
    n_checks++;
    if (bus.oStart !== 1'b1) $display("FAIL %s start: got %b want 1", name, bus.oStart);
    else n_pass++;
    @(negedge clk);
    bus.iCMDValid = 1'b0;
    bus.iOpcode   = '0;
    n_checks++;
    if (bus.oCMDReady !== 1'b0) $display("FAIL %s accept_ready: got %b want 0", name, bus.oCMDReady);
    else n_pass++;

    t = 0;
    while (!(bus.oACG_Command === 8'h40 && bus.oACG_CASelect === 1'b1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (t >= 20 || bus.oACG_Command !== 8'h40 || bus.oACG_CASelect !== 1'b1 ||
        bus.oACG_CAData !== 40'hEE_0000_0000 || bus.oACG_NumOfData !== 16'd1 ||
        bus.oACG_TargetWay !== way || bus.oACG_CommandOption !== 3'b000)
      $display("FAIL %s cmd_issue: got cmd=%h sel=%b ca=%h n=%0d way=%b want cmd=40 sel=1 ca=ee00000000 n=1 way=%b",
               name, bus.oACG_Command, bus.oACG_CASelect, bus.oACG_CAData, bus.oACG_NumOfData,
               bus.oACG_TargetWay, way);
    else n_pass++;

    bus.iACG_LastStep = 8'h40;
    @(negedge clk);
    bus.iACG_LastStep = 8'h00;
    n_checks++;
    if (bus.oACG_Command !== 8'h40 || bus.oACG_CASelect !== 1'b0 ||
        bus.oACG_CAData !== {addr, 32'h0} || bus.oACG_NumOfData !== 16'd1)
      $display("FAIL %s addr_issue: got cmd=%h sel=%b ca=%h n=%0d want cmd=40 sel=0 ca=%h n=1", name,
               bus.oACG_Command, bus.oACG_CASelect, bus.oACG_CAData, bus.oACG_NumOfData,
               {addr, 32'h0});
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.oACG_Command !== 8'h40 || bus.oACG_CASelect !== 1'b0)
      $display("FAIL %s addr_hold: got cmd=%h sel=%b want cmd=40 sel=0", name, bus.oACG_Command,
               bus.oACG_CASelect);
    else n_pass++;
    bus.iACG_LastStep = 8'h40;
    @(negedge clk);
    bus.iACG_LastStep = 8'h00;
    n_checks++;
    if (bus.oACG_Command !== 8'h00 || bus.oACG_CASelect !== 1'b1 || bus.oACG_CAData !== 40'h0)
      $display("FAIL %s after_addr: got cmd=%h sel=%b ca=%h want cmd=00 sel=1 ca=0", name,
               bus.oACG_Command, bus.oACG_CASelect, bus.oACG_CAData);
    else n_pass++;

    // Only the target way goes busy; the others stay ready and must be masked off.
    bus.iACG_ReadyBusy = ~way;
    ok = 1'b1;
    repeat (rb_low) begin
      @(negedge clk);
      if (bus.oACG_Command !== 8'h00) ok = 1'b0;
    end
    n_checks++;
    if (!ok) $display("FAIL %s rb_wait: got data request while busy want none", name);
    else n_pass++;
    bus.iACG_ReadyBusy = '1;
    t = 0;
    while (bus.oACG_Command !== 8'h10 && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t < 1 || t > 3 || bus.oACG_NumOfData !== 16'd4 || bus.oACG_ReadReady !== 1'b1)
      $display("FAIL %s data_req: got latency=%0d cmd=%h n=%0d rr=%b want latency<=3 cmd=10 n=4 rr=1",
               name, t, bus.oACG_Command, bus.oACG_NumOfData, bus.oACG_ReadReady);
    else n_pass++;

    for (int i = 0; i < nwords; i++) begin
      bus.iACG_ReadValid = 1'b1;
      bus.iACG_ReadData  = words[i];
      bus.iACG_ReadLast  = (i == nwords - 1);
      @(negedge clk);
      if (abort) break;
    end
    bus.iACG_ReadValid = 1'b0;
    bus.iACG_ReadLast  = 1'b0;

    if (abort) begin
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_vec() !== ResetVec)
        $display("FAIL %s async_reset: got %h want %h", name, out_vec(), ResetVec);
      else n_pass++;
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      return;
    end

    bus.iReadReady    = (rdy_delay == 0);
    bus.iACG_LastStep = 8'h10;
    @(negedge clk);
    bus.iACG_LastStep = 8'h00;
    t = 0;
    while (bus.oReadValid !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    got = bus.oReadData;
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 32'hDEAD_BEEF;
    n_checks++;
    if (t >= 10 || got !== exp || bus.oReadLast !== 1'b1)
      $display("FAIL %s result: got data=%h last=%b want data=%h last=1", name, got,
               bus.oReadLast, exp);
    else n_pass++;

    if (rdy_delay > 0) begin
      ok = 1'b1;
      repeat (rdy_delay) begin
        @(negedge clk);
        if (bus.oReadValid !== 1'b1 || bus.oReadData !== got || bus.oLastStep !== 1'b0) ok = 1'b0;
      end
      n_checks++;
      if (!ok) $display("FAIL %s backpressure: got valid/data unstable want held", name);
      else n_pass++;
      bus.iReadReady = 1'b1;
    end
    @(negedge clk);
    bus.iReadReady = 1'b0;
    n_checks++;
    if (bus.oLastStep !== 1'b1 || bus.oReadValid !== 1'b0 || bus.oCMDReady !== 1'b1)
      $display("FAIL %s last_step: got last=%b valid=%b rdy=%b want 1 0 1", name, bus.oLastStep,
               bus.oReadValid, bus.oCMDReady);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.oLastStep !== 1'b0) $display("FAIL %s last_pulse: got %b want 0", name, bus.oLastStep);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_basic();
    run_op("basic", 8'h01, 4'b0001, 2, 16'h1400, 16'h0000, 16'h0, 5, 0, 1'b0);
  endtask

  task automatic test_long_busy();
    run_op("long_busy", 8'h90, 4'b0100, 2, 16'h1234, 16'h5678, 16'h0, 50, 0, 1'b0);
  endtask

  task automatic test_read_backpressure();
    run_op("backpressure", 8'h02, 4'b1000, 2, 16'h0F0F, 16'hA5A5, 16'h0, 6, 10, 1'b0);
  endtask

  task automatic test_extra_words();
    run_op("extra_words", 8'h10, 4'b0010, 3, 16'hAAAA, 16'hBBBB, 16'hCCCC, 5, 0, 1'b0);
  endtask

  task automatic test_short_read();
    run_op("short_read", 8'h80, 4'b0001, 1, 16'h00C3, 16'h0, 16'h0, 5, 0, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    run_op("abort", 8'h01, 4'b0010, 2, 16'h7777, 16'h8888, 16'h0, 5, 0, 1'b1);
    run_op("after_abort", 8'h01, 4'b0010, 2, 16'h1400, 16'h0001, 16'h0, 5, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_a", 8'hA0, 4'b0001, 2, 16'h0102, 16'h0304, 16'h0, 5, 0, 1'b0);
    run_op("b2b_b", 8'hB0, 4'b0100, 2, 16'hFEDC, 16'hBA98, 16'h0, 5, 2, 1'b0);
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_wrong_opcode();
    test_basic();
    test_long_busy();
    test_read_backpressure();
    test_extra_words();
    test_short_read();
    test_reset_mid_op();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nfc_command_get_feature.md
# nfc_command_get_feature

Command executor that issues a NAND GET FEATURES operation (EEh + one feature-address byte), waits out the busy period, reads the four parameter bytes P1..P4 back through the ACG data-input primitive and returns them as one 32-bit word. It is the read-side companion of the SET FEATURES executor. It sits beside that executor on the shared command bus and ACG (atomic command generator) port, and is selected by `CommandID`.

## Interface
Parameters:
- `NumberOfWays`, 4, number of NAND ways (width of way masks)
- `CommandID`, 6'b000011, opcode this block answers to
- `TargetID`, 5'b00101, target identifier (reserved, not decoded)

Ports:
- `iSystemClock`  in  1  system clock; all logic on rising edge
- `iReset_n`  in  1  reset; one clock, asynchronous assert, active-low
- `iOpcode`  in  6  command opcode
- `iAddress`  in  8  feature address; sampled on start
- `iCMDValid`  in  1  command valid
- `oCMDReady`  out  1  block idle and accepting
- `iWaySelect`  in  NumberOfWays  target way mask
- `oStart`  out  1  combinational: `iOpcode==CommandID & iCMDValid`
- `oLastStep`  out  1  one-cycle pulse when operation completes
- `oReadData`  out  32  {P1,P2,P3,P4}
- `oReadLast`  out  1  high with `oReadValid` (single beat)
- `oReadValid`  out  1  result valid
- `iReadReady`  in  1  result consumer ready
- `oACG_Command`  out  8  one-hot primitive request: bit6 CA latch, bit4 data-in
- `oACG_CommandOption`  out  3  always 3'b000
- `iACG_Ready`  in  8  primitive ready flags
- `iACG_LastStep`  in  8  primitive completion pulses
- `oACG_TargetWay`  out  NumberOfWays  way mask to ACG
- `oACG_NumOfData`  out  16  byte/cycle count for the active primitive
- `oACG_CASelect`  out  1  1 = command latch, 0 = address latch
- `oACG_CAData`  out  40  CA byte in [39:32]
- `iACG_ReadData`  in  16  data-in word
- `iACG_ReadLast`  in  1  last data-in word
- `iACG_ReadValid`  in  1  data-in valid
- `oACG_ReadReady`  out  1  data-in ready
- `iACG_ReadyBusy`  in  NumberOfWays  per-way R/B#, 1 = ready

## Operation
- States: RESET, READY, CMDLatch, CMDIssue, ADDRIssue, WaitRBLow, WaitRBHigh, DATARead, ResultOut.
- RESET -> READY unconditionally.
- READY -> CMDLatch on `oStart`. Capture `iWaySelect` into TargetWay and `iAddress` into the feature register.
- CMDLatch -> CMDIssue.
- CMDIssue: Command=8'h40, CASelect=1, CAData=40'hEE_00_00_00_00, NumOfData=1. Exit on `iACG_LastStep[6]`.
- ADDRIssue: Command=8'h40, CASelect=0, CAData={addr,32'h0}, NumOfData=1. Exit on `iACG_LastStep[6]`.
- WaitRBLow: exit when synced way-busy==0.
- WaitRBHigh: exit when synced way-busy==1.
- DATARead: Command=8'h10, NumOfData=4, `oACG_ReadReady`=1.
  - Each `iACG_ReadValid&oACG_ReadReady` handshake stores a word: word0 -> [31:16], word1 -> [15:0].
  - A word counter saturates at 2; extra words are dropped.
  - Exit on `iACG_LastStep[4]`.
- ResultOut: `oReadValid`=`oReadLast`=1 with data held. On `iReadReady`: pulse `oLastStep` for one cycle, go to READY.
- R/B sync:
  - `rBusy <= TargetWay & iACG_ReadyBusy`
  - `rWayRB <= |rBusy`
  - Two-cycle latency; these registers are also reset.
- In any state other than CMDIssue, ADDRIssue and DATARead: Command=0, NumOfData=0, CASelect=1, CAData=0.

## Timing
- Reset values:
  - `oCMDReady`=1
  - `oLastStep`=0
  - `oReadValid`=`oReadLast`=0
  - `oReadData`=0
  - `oACG_Command`=0, `oACG_CommandOption`=0
  - `oACG_TargetWay`=0
  - `oACG_NumOfData`=0
  - `oACG_CASelect`=1, `oACG_CAData`=0
  - `oACG_ReadReady`=0
- All ACG and handshake outputs are registered from the next state, so they take effect one cycle after the transition condition.
- `oCMDReady` drops the cycle after acceptance and returns high with the cycle entering READY.
- CMD→ADDR: at least one cycle between `LastStep[6]` pulses is guaranteed by the ACG. The FSM must not double-advance on a single pulse.
- `iReadReady` already high on entry to ResultOut: valid is held for exactly one cycle, then `oLastStep` pulses.
- DATARead exit is driven only by `LastStep[4]`. If fewer than 2 words arrived, unwritten halves keep their previous (cleared-at-CMDLatch) zero value.
- Asynchronous reset mid-operation: immediate return to reset values and the RESET state. Any in-flight ACG primitive is abandoned.

## Structure
- Shared package (`nfc_pkg`):
  - ACG primitive bit indices (CA latch=6, data-out=5, data-in=4)
  - NAND opcodes (8'hEE get features, 8'hEF set features)
  - Feature-parameter byte count (4)
- One sub-module: `nfc_rb_sync`, the two-stage way-masked ready/busy synchroniser; shareable with the other command executors.

## Test plan
- Opcode 6'b000011, addr 8'h01, way 4'b0001; model returns 16'h1400, 16'h0000 -> CAData sequence EEh then 01h (CASelect 1 then 0), `oReadData`=32'h1400_0000, one `oLastStep` pulse.
- Wrong opcode 6'b000010 with `iCMDValid` -> `oStart`=0, FSM stays READY, `oCMDReady`=1.
- R/B# held low 50 cycles after address -> stays in WaitRBHigh, no DATARead request until R/B# rises, then Command=8'h10 within 3 cycles.
- `iReadReady` low for 10 cycles in ResultOut -> valid and data stable; `oLastStep` one cycle after `iReadReady` rises.
- Model supplies 3 words (16'hAAAA, 16'hBBBB, 16'hCCCC) -> result 32'hAAAA_BBBB, third word dropped.
- `iReset_n` low during DATARead -> all outputs at reset values the same cycle; a subsequent command completes normally.
